// File: rtl/reg_dump_reader_if.sv
// Bundle of signals between the register dump engine, the register file read
// port and the downstream debug stream consumer.
interface reg_dump_reader_if;
    logic        start;
    logic        abort;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    // master: the dump engine itself
    modport master (
        input  start, abort, rs_data, out_ready,
        output rs_addr, out_valid, out_index, out_data, busy, done, checksum
    );

    // slave: the environment (host, register file, stream sink)
    modport slave (
        output start, abort, rs_data, out_ready,
        input  rs_addr, out_valid, out_index, out_data, busy, done, checksum
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file read port one index at a time and streams each
// {index, value} pair over valid/ready, keeping an XOR checksum of accepted words.
module reg_dump_reader #(
    parameter int NUM_REGS  = 32,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    reg_dump_reader_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [4:0] FIRST_IDX = SKIP_ZERO ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic        r_out_valid;
    logic [4:0]  r_out_index;
    logic [31:0] r_out_data;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_checksum;

    logic w_last;
    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_index <= 5'd0;
            r_out_data  <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_idx      <= FIRST_IDX;
                        r_checksum <= 32'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_data  <= bus.rs_data;
                        r_out_index <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // An abort coinciding with out_ready discards the word unaccepted.
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (bus.out_ready) begin
                        r_checksum  <= r_checksum ^ r_out_data;
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rs_addr   = r_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.out_index = r_out_index;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.checksum  = r_checksum;
endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a 32-register/skip-zero instance and a
// 4-register/no-skip instance, each with its own register file model.
module tb_reg_dump_reader;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_dump_reader_if ifa();
    reg_dump_reader_if ifb();

    reg_dump_reader #(.NUM_REGS(32), .SKIP_ZERO(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    reg_dump_reader #(.NUM_REGS(4),  .SKIP_ZERO(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    logic [31:0] rf_a [32];
    logic [31:0] rf_b [4];
    assign ifa.rs_data = rf_a[ifa.rs_addr];
    assign ifb.rs_data = rf_b[ifb.rs_addr[1:0]];

    int checks   = 0;
    int failures = 0;
    word_t exp_a[$];
    word_t exp_b[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor for instance A: pops the scoreboard on each handshake and
    // checks that a pending word stays stable.
    word_t prev_a;
    logic  pv_a = 1'b0;
    always @(negedge clk) begin
        word_t w;
        if (rst) begin
            pv_a = 1'b0;
        end else begin
            if (pv_a && ifa.out_valid) begin
                chk("a_stable_index", 32'(ifa.out_index), 32'(prev_a.idx));
                chk("a_stable_data", ifa.out_data, prev_a.data);
            end
            if (ifa.out_valid && ifa.out_ready && !ifa.abort) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_word", 32'(ifa.out_index), 32'hFFFF_FFFF);
                end else begin
                    w = exp_a.pop_front();
                    chk("a_word_index", 32'(ifa.out_index), 32'(w.idx));
                    chk("a_word_data", ifa.out_data, w.data);
                end
                pv_a = 1'b0;
            end else begin
                pv_a   = ifa.out_valid;
                prev_a = '{idx: ifa.out_index, data: ifa.out_data};
            end
        end
    end

    always @(negedge clk) begin
        word_t w;
        if (!rst && ifb.out_valid && ifb.out_ready && !ifb.abort) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected_word", 32'(ifb.out_index), 32'hFFFF_FFFF);
            end else begin
                w = exp_b.pop_front();
                chk("b_word_index", 32'(ifb.out_index), 32'(w.idx));
                chk("b_word_data", ifb.out_data, w.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ramp_a(input int skip_k, input logic [31:0] kval);
        for (int i = 1; i < 32; i++) begin
            if (i == skip_k) exp_a.push_back('{idx: 5'(i), data: kval});
            else             exp_a.push_back('{idx: 5'(i), data: 32'h1000_0000 + 32'(i)});
        end
    endtask

    task automatic start_a();
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
    endtask

    // Counts falling edges after the start edge until done is seen.
    task automatic wait_done_a(input int limit, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!ifa.done && c < limit);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_a_rs_addr"},   32'(ifa.rs_addr), 32'd0);
        chk({tag, "_a_out_valid"}, 32'(ifa.out_valid), 32'd0);
        chk({tag, "_a_out_index"}, 32'(ifa.out_index), 32'd0);
        chk({tag, "_a_out_data"},  ifa.out_data, 32'd0);
        chk({tag, "_a_busy"},      32'(ifa.busy), 32'd0);
        chk({tag, "_a_done"},      32'(ifa.done), 32'd0);
        chk({tag, "_a_checksum"},  ifa.checksum, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1;
        ifa.start = 0; ifa.abort = 0; ifa.out_ready = 0;
        ifb.start = 0; ifb.abort = 0; ifb.out_ready = 0;
        for (int i = 0; i < 32; i++) rf_a[i] = 32'h1000_0000 + 32'(i);
        rf_b[0] = 32'd0; rf_b[1] = 32'd5; rf_b[2] = 32'd6; rf_b[3] = 32'd7;
        tick(3);
        chk_reset_outputs("reset");
        chk("reset_b_busy", 32'(ifb.busy), 32'd0);
        chk("reset_b_checksum", ifb.checksum, 32'd0);
        rst = 1'b0;
        tick(2);

        // Full dump, ready held high: latency and checksum.
        push_ramp_a(0, 32'd0);
        ifa.out_ready = 1'b1;
        start_a();
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                chk("t1_busy_n1", 32'(ifa.busy), 32'd1);
                chk("t1_valid_n1", 32'(ifa.out_valid), 32'd0);
            end
            if (c == 2) chk("t1_valid_n2", 32'(ifa.out_valid), 32'd1);
        end while (!ifa.done && c < 200);
        chk("t1_done_latency", 32'(c), 32'd63);
        chk("t1_checksum", ifa.checksum, 32'h1000_0000);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(ifa.done), 32'd0);
        chk("t1_busy_after", 32'(ifa.busy), 32'd0);
        chk("t1_queue_empty", 32'(exp_a.size()), 32'd0);
        tick(2);

        // Same dump with out_ready toggling.
        push_ramp_a(0, 32'd0);
        ifa.out_ready = 1'b0;
        start_a();
        c = 0;
        while (!ifa.done && c < 1000) begin
            ifa.out_ready = 1'($urandom_range(0, 1));
            tick(1);
            c++;
        end
        chk("t2_done_seen", 32'(ifa.done), 32'd1);
        ifa.out_ready = 1'b1;
        tick(2);
        chk("t2_checksum", ifa.checksum, 32'h1000_0000);
        chk("t2_queue_empty", 32'(exp_a.size()), 32'd0);

        // Four-register instance including index 0.
        exp_b.push_back('{idx: 5'd0, data: 32'd0});
        exp_b.push_back('{idx: 5'd1, data: 32'd5});
        exp_b.push_back('{idx: 5'd2, data: 32'd6});
        exp_b.push_back('{idx: 5'd3, data: 32'd7});
        ifb.out_ready = 1'b1;
        ifb.start = 1'b1;
        tick(1);
        ifb.start = 1'b0;
        c = 0;
        while (!ifb.done && c < 100) begin
            tick(1);
            c++;
        end
        chk("t3_done_seen", 32'(ifb.done), 32'd1);
        chk("t3_checksum", ifb.checksum, 32'h0000_0004);
        tick(2);
        chk("t3_queue_empty", 32'(exp_b.size()), 32'd0);

        // Abort in HOLD of the third word while ready is high.
        exp_a.push_back('{idx: 5'd1, data: 32'h1000_0001});
        exp_a.push_back('{idx: 5'd2, data: 32'h1000_0002});
        ifa.out_ready = 1'b1;
        start_a();
        c = 0;
        while (!(ifa.out_valid && ifa.out_index == 5'd3) && c < 50) begin
            tick(1);
            c++;
        end
        chk("t4_reached_word3", 32'(ifa.out_index), 32'd3);
        ifa.abort = 1'b1;
        tick(1);
        ifa.abort = 1'b0;
        chk("t4_valid_after_abort", 32'(ifa.out_valid), 32'd0);
        chk("t4_busy_after_abort", 32'(ifa.busy), 32'd0);
        chk("t4_checksum_partial", ifa.checksum, 32'h0000_0003);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_done", 32'(ifa.done), 32'd0);
        end
        chk("t4_queue_empty", 32'(exp_a.size()), 32'd0);
        tick(1);

        // Repeated starts while busy, then reset mid-dump, then a fresh dump.
        push_ramp_a(0, 32'd0);
        start_a();
        for (int i = 0; i < 12; i++) begin
            ifa.start = (i % 2 == 0);
            tick(1);
        end
        ifa.start = 1'b0;
        chk("t5_busy_before_rst", 32'(ifa.busy), 32'd1);
        rst = 1'b1;
        tick(1);
        chk_reset_outputs("t5_rst");
        rst = 1'b0;
        exp_a.delete();
        tick(1);
        push_ramp_a(0, 32'd0);
        start_a();
        wait_done_a(200, c);
        chk("t5_done_latency", 32'(c), 32'd63);
        chk("t5_checksum", ifa.checksum, 32'h1000_0000);
        tick(2);
        chk("t5_queue_empty", 32'(exp_a.size()), 32'd0);

        // Write into r[5] just before its READ; start and abort together.
        push_ramp_a(5, 32'hDEAD_BEEF);
        ifa.abort = 1'b1;
        start_a();
        ifa.abort = 1'b0;
        chk("t6_start_with_abort", 32'(ifa.busy), 32'd1);
        c = 0;
        while (!(ifa.out_valid && ifa.out_index == 5'd4) && c < 50) begin
            tick(1);
            c++;
        end
        rf_a[5] = 32'hDEAD_BEEF;
        wait_done_a(200, c);
        chk("t6_done_seen", 32'(ifa.done), 32'd1);
        chk("t6_checksum", ifa.checksum, 32'hDEAD_BEEA);
        rf_a[5] = 32'h1000_0005;
        tick(2);
        chk("t6_queue_empty", 32'(exp_a.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-side engine for the CPU register file: on a start command it walks the register file's asynchronous read port one index at a time and streams each `{index, value}` pair out over a valid/ready handshake. It sits beside the core, sharing one read-port address/data pair, and feeds the team's on-board display/UART debug path. It also produces a running XOR checksum of all emitted words for quick integrity comparison.

## Interface

Parameters:
- `NUM_REGS`, default 32: number of registers walked; index width is 5 bits, so `NUM_REGS` must be in 2..32.
- `SKIP_ZERO`, default 1: when 1, the walk starts at index 1 and x0 is never emitted; when 0, it starts at 0.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `abort`  in  1  cancel a dump in progress; highest priority after `rst`.
- `rs_addr`  out  5  address to the register file read port.
- `rs_data`  in  32  combinational read data for `rs_addr`, valid in the same cycle.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_index`  out  5  register index of the current word.
- `out_data`  out  32  register value of the current word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `checksum`  out  32  XOR of all words accepted in the current or last dump.

## Operation

- States: IDLE, READ, HOLD, DONE. Internal index register `idx` (5 bits). `rs_addr = idx` in all states.
- IDLE: `busy`=0 and `out_valid`=0. If `start`=1, load `idx` with `SKIP_ZERO ? 1 : 0`, clear `checksum`, and go to READ. `start` is ignored outside IDLE.
- READ: one cycle. Capture `out_data <= rs_data`, `out_index <= idx`, and `out_valid <= 1`, then go to HOLD.
- HOLD: `out_valid`=1, with `out_data` and `out_index` held stable. On `out_ready`=1 (a handshake):
  - `checksum <= checksum ^ out_data`.
  - `out_valid <= 0`.
  - If `idx == NUM_REGS-1`, go to DONE; otherwise increment `idx` and go to READ.
- DONE: one cycle with `done`=1 and `busy`=1, then go to IDLE. `checksum` holds its value until the next `start` is accepted.
- Snapshot semantics: each word reflects the register contents in its READ cycle. The register file is not frozen across the whole dump, and writes between words are visible in later words.
- `abort` in READ, HOLD or DONE:
  - Go to IDLE on the next edge with `out_valid` <= 0.
  - No `done` pulse. `checksum` keeps the partial value.
  - Simultaneous `abort` and `out_ready` in HOLD: the abort wins, and the word counts as not accepted (no checksum update).
- `abort` in IDLE has no effect. `start` and `abort` asserted together in IDLE: the start is accepted.

## Timing

- Reset values: state=IDLE, `idx`=0, `rs_addr`=0, `out_valid`=0, `out_index`=0, `out_data`=0, `busy`=0, `done`=0, `checksum`=0.
- `rst` mid-dump returns all of the above to reset values on the next edge.
- Latency:
  - Start accepted at edge N: `busy`=1 from N+1, and the first `out_valid`=1 from N+2.
  - With `out_ready` held high, one word is accepted every 2 cycles.
  - `SKIP_ZERO`=1 with `NUM_REGS`=32: 31 words. The last handshake is followed by `done` high for exactly one cycle, then `busy`=0 the next cycle.
  - Full dump, ready always high: start edge to `done`=1 takes 1 + 2·31 = 63 cycles.
- Valid/ready rules:
  - Once `out_valid` rises, it stays high with stable data and index until a handshake, `abort` or `rst`.
  - `out_ready` may toggle freely, and `out_valid` does not depend combinationally on `out_ready`.
- `idx` never wraps: the terminal check precedes the increment, so it never passes `NUM_REGS-1`.
- Checksum uses 32-bit XOR with no carries.

## Test plan

- Preload the register file with r[i]=0x1000_0000+i; pulse `start` with ready held high.
  - Required: 31 words, indices 1..31 in order, data matching r[i].
  - `done` rises exactly 63 cycles after the start edge; `checksum` = XOR over i=1..31 of (0x1000_0000+i) = 0x1000_0000.
- Same preload, toggle `out_ready` randomly.
  - Required: data and index never change while valid is high and not accepted.
  - Identical word sequence and checksum to the first test.
- `SKIP_ZERO`=0, `NUM_REGS`=4, registers hold 0,5,6,7.
  - Required: 4 words with indices 0..3; the index-0 word carries 0; `checksum`=0x4.
- Assert `abort` in HOLD of the 3rd word while `out_ready`=1.
  - Required: that word is not counted; `out_valid`=0 and `busy`=0 next cycle; no `done`; `checksum` = r1^r2.
- Pulse `start` repeatedly while busy, then assert `rst` mid-dump.
  - Required: extra starts have no effect; `rst` gives all outputs their reset values the next cycle.
  - A fresh `start` afterwards produces a complete, correct dump.
- In the cycle before word k's READ, write 0xDEAD_BEEF into r[k].
  - Required: word k carries 0xDEAD_BEEF.
